// File: rtl/multicycle_control.sv
// Main control FSM for the multicycle RV32 core (LW, SW, BEQ, R-type ADD/SUB/AND/OR).
// Sequences the shared ALU, register file and unified memory port; traps on illegal opcode or memory timeout.
module multicycle_control #(
   parameter int TIMEOUT_CYCLES = 255,
   parameter bit TIMEOUT_EN     = 1'b1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [6:0] opcode,
   input  logic       zero,
   input  logic       mem_ready,
   output logic       mem_req,
   output logic       mem_write,
   output logic       adr_src,
   output logic       ir_write,
   output logic       pc_write,
   output logic       reg_write,
   output logic [1:0] alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [1:0] alu_op,
   output logic [1:0] result_src,
   output logic       instr_retired,
   output logic       trap,
   output logic [1:0] trap_cause
);

   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   localparam logic [6:0] OP_LW   = 7'b0000011;
   localparam logic [6:0] OP_SW   = 7'b0100011;
   localparam logic [6:0] OP_R    = 7'b0110011;
   localparam logic [6:0] OP_BEQ  = 7'b1100011;

   typedef enum logic [3:0] {
      S_FETCH, S_DECODE, S_MEM_ADR, S_MEM_READ, S_MEM_WB,
      S_MEM_WRITE, S_EXEC_R, S_ALU_WB, S_BRANCH, S_TRAP
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] wait_q, wait_d;
   logic             trap_q, trap_d;
   logic [1:0]       cause_q, cause_d;
   logic             timeout_hit;

   // Only meaningful in states that hold mem_req high.
   assign timeout_hit = TIMEOUT_EN && !mem_ready && (wait_q == CNT_W'(TIMEOUT_CYCLES));

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_FETCH;
         wait_q  <= '0;
         trap_q  <= 1'b0;
         cause_q <= 2'b00;
      end else begin
         state_q <= state_d;
         wait_q  <= wait_d;
         trap_q  <= trap_d;
         cause_q <= cause_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      trap_d        = trap_q;
      cause_d       = cause_q;
      mem_req       = 1'b0;
      mem_write     = 1'b0;
      adr_src       = 1'b0;
      ir_write      = 1'b0;
      pc_write      = 1'b0;
      reg_write     = 1'b0;
      alu_src_a     = 2'b00;
      alu_src_b     = 2'b00;
      alu_op        = 2'b00;
      result_src    = 2'b00;
      instr_retired = 1'b0;

      case (state_q)
         S_FETCH: begin
            mem_req    = 1'b1;
            alu_src_b  = 2'b10;
            result_src = 2'b10;
            if (timeout_hit) begin
               state_d = S_TRAP;
               trap_d  = 1'b1;
               cause_d = 2'b10;
            end else if (mem_ready) begin
               ir_write = 1'b1;
               pc_write = 1'b1;
               state_d  = S_DECODE;
            end
         end
         S_DECODE: begin
            // Branch target is computed here so BRANCH can load it from alu_out.
            alu_src_a = 2'b01;
            alu_src_b = 2'b01;
            case (opcode)
               OP_LW, OP_SW: state_d = S_MEM_ADR;
               OP_R:         state_d = S_EXEC_R;
               OP_BEQ:       state_d = S_BRANCH;
               default: begin
                  state_d = S_TRAP;
                  trap_d  = 1'b1;
                  cause_d = 2'b01;
               end
            endcase
         end
         S_MEM_ADR: begin
            alu_src_a = 2'b10;
            alu_src_b = 2'b01;
            state_d   = opcode[5] ? S_MEM_WRITE : S_MEM_READ;
         end
         S_MEM_READ: begin
            mem_req = 1'b1;
            adr_src = 1'b1;
            if (timeout_hit) begin
               state_d = S_TRAP;
               trap_d  = 1'b1;
               cause_d = 2'b10;
            end else if (mem_ready) begin
               state_d = S_MEM_WB;
            end
         end
         S_MEM_WB: begin
            result_src    = 2'b01;
            reg_write     = 1'b1;
            instr_retired = 1'b1;
            state_d       = S_FETCH;
         end
         S_MEM_WRITE: begin
            mem_req   = 1'b1;
            mem_write = 1'b1;
            adr_src   = 1'b1;
            if (timeout_hit) begin
               state_d = S_TRAP;
               trap_d  = 1'b1;
               cause_d = 2'b10;
            end else if (mem_ready) begin
               instr_retired = 1'b1;
               state_d       = S_FETCH;
            end
         end
         S_EXEC_R: begin
            alu_src_a = 2'b10;
            alu_op    = 2'b10;
            state_d   = S_ALU_WB;
         end
         S_ALU_WB: begin
            reg_write     = 1'b1;
            instr_retired = 1'b1;
            state_d       = S_FETCH;
         end
         S_BRANCH: begin
            alu_src_a     = 2'b10;
            alu_op        = 2'b01;
            pc_write      = zero;
            instr_retired = 1'b1;
            state_d       = S_FETCH;
         end
         default: state_d = S_TRAP;
      endcase

      // Reset aborts any access: strobes low, selects parked at their FETCH values.
      if (!rst_n) begin
         mem_req       = 1'b0;
         mem_write     = 1'b0;
         adr_src       = 1'b0;
         ir_write      = 1'b0;
         pc_write      = 1'b0;
         reg_write     = 1'b0;
         instr_retired = 1'b0;
         alu_src_a     = 2'b00;
         alu_src_b     = 2'b10;
         alu_op        = 2'b00;
         result_src    = 2'b10;
      end
   end

   // Counts consecutive unanswered request cycles; any other cycle clears it.
   always_comb begin
      wait_d = '0;
      if (mem_req && !mem_ready) begin
         wait_d = (wait_q == '1) ? wait_q : wait_q + CNT_W'(1);
      end
   end

   assign trap       = trap_q;
   assign trap_cause = cause_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: instruction sequences, reset abort, illegal-opcode trap,
// and watchdog behaviour on two small-timeout instances (enabled and disabled).
module tb_multicycle_control;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [6:0] opcode;
   logic       zero;
   logic       mem_ready;

   logic       mem_req, mem_write, adr_src, ir_write, pc_write, reg_write;
   logic [1:0] alu_src_a, alu_src_b, alu_op, result_src, trap_cause;
   logic       instr_retired, trap;

   logic       t_req, t_wr, t_adr, t_ir, t_pcw, t_rw, t_ret, t_trap;
   logic [1:0] t_a, t_b, t_op, t_rs, t_cause;
   logic       n_req, n_wr, n_adr, n_ir, n_pcw, n_rw, n_ret, n_trap;
   logic [1:0] n_a, n_b, n_op, n_rs, n_cause;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   multicycle_control dut (
      .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
      .mem_req(mem_req), .mem_write(mem_write), .adr_src(adr_src), .ir_write(ir_write),
      .pc_write(pc_write), .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
      .alu_op(alu_op), .result_src(result_src), .instr_retired(instr_retired),
      .trap(trap), .trap_cause(trap_cause)
   );

   multicycle_control #(.TIMEOUT_CYCLES(4), .TIMEOUT_EN(1'b1)) dut_t (
      .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(1'b0),
      .mem_req(t_req), .mem_write(t_wr), .adr_src(t_adr), .ir_write(t_ir),
      .pc_write(t_pcw), .reg_write(t_rw), .alu_src_a(t_a), .alu_src_b(t_b),
      .alu_op(t_op), .result_src(t_rs), .instr_retired(t_ret),
      .trap(t_trap), .trap_cause(t_cause)
   );

   multicycle_control #(.TIMEOUT_CYCLES(4), .TIMEOUT_EN(1'b0)) dut_n (
      .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(1'b0),
      .mem_req(n_req), .mem_write(n_wr), .adr_src(n_adr), .ir_write(n_ir),
      .pc_write(n_pcw), .reg_write(n_rw), .alu_src_a(n_a), .alu_src_b(n_b),
      .alu_op(n_op), .result_src(n_rs), .instr_retired(n_ret),
      .trap(n_trap), .trap_cause(n_cause)
   );

   // {req, wr, adr, ir, pcw, rw, a, b, op, rs, ret, trap, cause}
   logic [17:0] obs;
   assign obs = {mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
                 alu_src_a, alu_src_b, alu_op, result_src, instr_retired, trap, trap_cause};

   function automatic logic [17:0] v(input logic req, wr, adr, ir, pcw, rw,
                                     input logic [1:0] a, b, op, rs,
                                     input logic ret, trp, input logic [1:0] cause);
      return {req, wr, adr, ir, pcw, rw, a, b, op, rs, ret, trp, cause};
   endfunction

   task automatic check(input string tag, input logic [17:0] observed, input logic [17:0] expected);
      n_checks++;
      assert (observed === expected) else begin
         n_fail++;
         $error("FAIL %s observed=%b expected=%b", tag, observed, expected);
      end
   endtask

   // Apply inputs for one cycle, then check the main DUT's outputs for that cycle.
   task automatic cyc(input logic rst, rdy, input logic [6:0] op, input logic z,
                      input logic [17:0] expected, input string tag);
      @(negedge clk);
      rst_n     = rst;
      mem_ready = rdy;
      opcode    = op;
      zero      = z;
      #1;
      check(tag, obs, expected);
      $display("cycle t=%0t %s outputs=%b", $time, tag, obs);
   endtask

   initial begin
      logic [17:0] RST, FW, FR, DEC, MA, MR, MWB, MWW, MWR, EX, AWB, BRT, BRN, TRP1, RST_T;
      RST  = v(0,0,0,0,0,0, 2'b00,2'b10,2'b00,2'b10, 0,0,2'b00);
      FW   = v(1,0,0,0,0,0, 2'b00,2'b10,2'b00,2'b10, 0,0,2'b00);
      FR   = v(1,0,0,1,1,0, 2'b00,2'b10,2'b00,2'b10, 0,0,2'b00);
      DEC  = v(0,0,0,0,0,0, 2'b01,2'b01,2'b00,2'b00, 0,0,2'b00);
      MA   = v(0,0,0,0,0,0, 2'b10,2'b01,2'b00,2'b00, 0,0,2'b00);
      MR   = v(1,0,1,0,0,0, 2'b00,2'b00,2'b00,2'b00, 0,0,2'b00);
      MWB  = v(0,0,0,0,0,1, 2'b00,2'b00,2'b00,2'b01, 1,0,2'b00);
      MWW  = v(1,1,1,0,0,0, 2'b00,2'b00,2'b00,2'b00, 0,0,2'b00);
      MWR  = v(1,1,1,0,0,0, 2'b00,2'b00,2'b00,2'b00, 1,0,2'b00);
      EX   = v(0,0,0,0,0,0, 2'b10,2'b00,2'b10,2'b00, 0,0,2'b00);
      AWB  = v(0,0,0,0,0,1, 2'b00,2'b00,2'b00,2'b00, 1,0,2'b00);
      BRT  = v(0,0,0,0,1,0, 2'b10,2'b00,2'b01,2'b00, 1,0,2'b00);
      BRN  = v(0,0,0,0,0,0, 2'b10,2'b00,2'b01,2'b00, 1,0,2'b00);
      TRP1 = v(0,0,0,0,0,0, 2'b00,2'b00,2'b00,2'b00, 0,1,2'b01);
      RST_T = v(0,0,0,0,0,0, 2'b00,2'b10,2'b00,2'b10, 0,1,2'b01);

      rst_n = 1'b0; mem_ready = 1'b0; opcode = 7'b0; zero = 1'b0;

      cyc(0, 1, 7'b0000011, 0, RST, "reset1");
      cyc(0, 1, 7'b0000011, 0, RST, "reset2");

      // LW, no wait states: F, D, MA, MR, WB
      cyc(1, 1, 7'b0000011, 0, FR,  "lw_fetch");
      check("wdt_fetch_req_c1", {17'b0, t_req}, 18'd1);
      cyc(1, 1, 7'b0000011, 0, DEC, "lw_decode");
      cyc(1, 1, 7'b0000011, 0, MA,  "lw_memadr");
      cyc(1, 1, 7'b0000011, 0, MR,  "lw_memread");
      cyc(1, 1, 7'b0000011, 0, MWB, "lw_memwb");
      // dut_t: fifth FETCH cycle with counter at 4 -> still requesting, not yet trapped
      check("wdt_c5_trap", {16'b0, t_trap, t_req}, 18'b01);

      // SW with three wait cycles in MEM_WRITE
      cyc(1, 1, 7'b0100011, 0, FR,  "sw_fetch");
      check("wdt_trapped", {15'b0, t_req, t_trap, t_cause}, {15'b0, 1'b0, 1'b1, 2'b10});
      cyc(1, 1, 7'b0100011, 0, DEC, "sw_decode");
      cyc(1, 1, 7'b0100011, 0, MA,  "sw_memadr");
      cyc(1, 0, 7'b0100011, 0, MWW, "sw_wait1");
      cyc(1, 0, 7'b0100011, 0, MWW, "sw_wait2");
      cyc(1, 0, 7'b0100011, 0, MWW, "sw_wait3");
      cyc(1, 1, 7'b0100011, 0, MWR, "sw_ready");

      // BEQ taken then not taken
      cyc(1, 1, 7'b1100011, 1, FR,  "beq1_fetch");
      cyc(1, 1, 7'b1100011, 1, DEC, "beq1_decode");
      cyc(1, 1, 7'b1100011, 1, BRT, "beq1_branch");
      cyc(1, 1, 7'b1100011, 0, FR,  "beq0_fetch");
      cyc(1, 1, 7'b1100011, 0, DEC, "beq0_decode");
      cyc(1, 1, 7'b1100011, 0, BRN, "beq0_branch");

      // R-type
      cyc(1, 1, 7'b0110011, 0, FR,  "r_fetch");
      cyc(1, 1, 7'b0110011, 0, DEC, "r_decode");
      cyc(1, 1, 7'b0110011, 0, EX,  "r_exec");
      cyc(1, 1, 7'b0110011, 0, AWB, "r_aluwb");
      check("wdt_disabled_no_trap", {16'b0, n_trap, n_req}, 18'b01);
      check("wdt_still_trapped", {16'b0, t_trap, t_req}, 18'b10);

      // Reset during a MEM_WRITE wait aborts the store
      cyc(1, 1, 7'b0100011, 0, FR,  "abort_fetch");
      cyc(1, 1, 7'b0100011, 0, DEC, "abort_decode");
      cyc(1, 1, 7'b0100011, 0, MA,  "abort_memadr");
      cyc(1, 0, 7'b0100011, 0, MWW, "abort_wait");
      cyc(0, 0, 7'b0100011, 0, RST, "abort_reset");
      cyc(1, 0, 7'b0100011, 0, FW,  "abort_fetch_wait");

      // Illegal opcode traps and stays halted until reset
      cyc(1, 1, 7'b0010011, 0, FR,   "ill_fetch");
      cyc(1, 1, 7'b0010011, 0, DEC,  "ill_decode");
      cyc(1, 1, 7'b0010011, 0, TRP1, "ill_trap1");
      cyc(1, 1, 7'b0000011, 0, TRP1, "ill_trap2");
      cyc(1, 1, 7'b0110011, 1, TRP1, "ill_trap3");
      cyc(0, 1, 7'b0000011, 0, RST_T, "ill_reset");
      cyc(1, 1, 7'b0000011, 0, FR,   "ill_after_reset");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
